transmit: RTL

TRANSMIT -- requirements
Module: transmit

---
 rtl/uart_pkg.sv | 15 +
 rtl/transmit.sv | 89 ++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for transmitter and receiver: FSM states and 8N1 frame geometry.
package uart_pkg;

  typedef enum logic {
    IDLE         = 1'b0,
    TRANSMITTING = 1'b1
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // bit_cnt value while the stop bit is on the line
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

endpackage

// File: rtl/transmit.sv
// 8N1 UART transmitter with one-byte holding register; bit timing from the external baud strobe.
// Latency: write to start bit is 1 clk plus the wait for the next transmit_baud strobe.
// Backpressure: tbr=0 while the holding register is full; writes arriving then are dropped.
module transmit
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       transmit_baud,
  input  logic       transmit_write_en,
  input  logic [7:0] transmit_write_line,
  output logic       txd,
  output logic       tbr,
  output logic       tx_busy
);

  state_t                  state, state_nxt;
  logic [FRAME_BITS-1:0]   shifter, shifter_nxt;
  logic [3:0]              bit_cnt, bit_cnt_nxt;
  logic                    hold_full;
  logic [DATA_BITS-1:0]    hold_reg;
  logic                    load;

  always_comb begin
    state_nxt   = state;
    shifter_nxt = shifter;
    bit_cnt_nxt = bit_cnt;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (transmit_baud && hold_full) begin
          load        = 1'b1;
          shifter_nxt = {1'b1, hold_reg, 1'b0};
          bit_cnt_nxt = 4'd0;
          state_nxt   = TRANSMITTING;
        end
      end
      TRANSMITTING: begin
        if (transmit_baud) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = 4'd0;
            // a pending byte follows the stop bit with no idle gap
            if (hold_full) begin
              load        = 1'b1;
              shifter_nxt = {1'b1, hold_reg, 1'b0};
            end else begin
              shifter_nxt = '1;
              state_nxt   = IDLE;
            end
          end else begin
            shifter_nxt = {1'b1, shifter[FRAME_BITS-1:1]};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shifter <= '1;
      bit_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      shifter <= shifter_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // load only happens with hold_full set, so a same-cycle write always sees tbr=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (transmit_write_en && !hold_full) begin
      hold_full <= 1'b1;
      hold_reg  <= transmit_write_line;
    end
  end

  assign txd     = shifter[0];
  assign tbr     = ~hold_full;
  assign tx_busy = (state == TRANSMITTING);

endmodule
